// File: rtl/game_flow_if.sv
// Button inputs and decoder-facing codes of the color-match game sequencer.
interface game_flow_if;
    logic       btn_next;
    logic       btn_select;
    logic [2:0] step;
    logic [2:0] variety;
    logic [2:0] match;
    logic [2:0] variety1;
    logic [3:0] attempts;

    // Board / bench side: drives the raw buttons, watches the codes.
    modport master (
        output btn_next, btn_select,
        input  step, variety, match, variety1, attempts
    );

    // Sequencer side.
    modport slave (
        input  btn_next, btn_select,
        output step, variety, match, variety1, attempts
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Round sequencer for the 4-square color-match game: debounces the two
// buttons and walks pick/pick/reveal/pick/pick/reveal/win, producing the
// codes the action decoder turns into square states.
// Pairing is fixed: square i partners with square 3-i.
module game_flow_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REVEAL_CYCLES   = 25000000
) (
    input logic        clk25MHz,
    input logic        rst,
    game_flow_if.slave bus
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

    typedef enum logic [2:0] {
        PICK1 = 3'b000,
        PICK2 = 3'b001,
        SHOW2 = 3'b010,
        PICK3 = 3'b011,
        PICK4 = 3'b100,
        SHOW4 = 3'b101,
        WIN   = 3'b110
    } state_t;

    // index 0 = next, index 1 = select
    logic [1:0]    raw, sync1, sync2, lvl, pulse;
    logic [DW-1:0] cnt [2];
    logic          nxt_p, sel_p;

    state_t        state, state_n;
    logic [1:0]    variety, variety_n, match, match_n, variety1, variety1_n;
    logic [1:0]    m_inc;
    logic [3:0]    attempts, attempts_n;
    logic [TW-1:0] timer, timer_n;

    assign raw = {bus.btn_select, bus.btn_next};

    // Synchronize raw buttons, accept a level only after it has differed
    // from the accepted level for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            pulse <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl[i]   <= sync2[i];
                    cnt[i]   <= '0;
                    pulse[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Select has priority when both pulses land in the same cycle.
    assign sel_p = pulse[1];
    assign nxt_p = pulse[0] & ~pulse[1];

    // State and output registers.
    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            state    <= PICK1;
            variety  <= '0;
            match    <= '0;
            variety1 <= '0;
            attempts <= '0;
            timer    <= '0;
        end else begin
            state    <= state_n;
            variety  <= variety_n;
            match    <= match_n;
            variety1 <= variety1_n;
            attempts <= attempts_n;
            timer    <= timer_n;
        end
    end

    // Next-state and next-code logic; everything holds unless a rule fires.
    always_comb begin
        state_n    = state;
        variety_n  = variety;
        match_n    = match;
        variety1_n = variety1;
        attempts_n = attempts;
        timer_n    = timer;
        m_inc      = match + 2'd1;
        if (m_inc == variety) m_inc = m_inc + 2'd1;
        case (state)
            PICK1: begin
                if (sel_p) begin
                    match_n = (variety == 2'd0) ? 2'd1 : 2'd0;
                    state_n = PICK2;
                end else if (nxt_p) begin
                    variety_n = variety + 2'd1;
                end
            end
            PICK2: begin
                if (sel_p) begin
                    timer_n = '0;
                    state_n = SHOW2;
                end else if (nxt_p) begin
                    match_n = m_inc;
                end
            end
            SHOW2: begin
                if (timer == TW'(REVEAL_CYCLES - 1)) begin
                    timer_n = '0;
                    if (match == 2'd3 - variety) begin
                        variety1_n = (variety == 2'd0 || variety == 2'd3) ? 2'd1 : 2'd2;
                        state_n    = PICK3;
                    end else begin
                        if (attempts != 4'd15) attempts_n = attempts + 4'd1;
                        variety_n = '0;
                        match_n   = '0;
                        state_n   = PICK1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            PICK3: begin
                if (sel_p)      state_n    = PICK4;
                else if (nxt_p) variety1_n = 2'd3 - variety1;
            end
            PICK4: begin
                if (sel_p) begin
                    timer_n = '0;
                    state_n = SHOW4;
                end
            end
            SHOW4: begin
                if (timer == TW'(REVEAL_CYCLES - 1)) begin
                    timer_n = '0;
                    state_n = WIN;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = WIN;
        endcase
    end

    assign bus.step     = state;
    assign bus.variety  = {1'b0, variety};
    assign bus.match    = {1'b0, match};
    assign bus.variety1 = {1'b0, variety1};
    assign bus.attempts = attempts;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed plus randomized bench for game_flow_ctrl against a rule-level
// model of the game (phase number and pick values as plain integers).
module tb_game_flow_ctrl;
    logic clk25MHz = 1'b0;
    logic rst      = 1'b1;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    // reference model of the game
    int m_ph, m_var, m_match, m_v1, m_att;

    always #5 clk25MHz = ~clk25MHz;

    game_flow_if gif ();

    game_flow_ctrl #(.DEBOUNCE_CYCLES(4), .REVEAL_CYCLES(8)) dut (
        .clk25MHz (clk25MHz),
        .rst      (rst),
        .bus      (gif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".step"},     32'(gif.step),     32'(m_ph));
        chk({tag, ".variety"},  32'(gif.variety),  32'(m_var));
        chk({tag, ".match"},    32'(gif.match),    32'(m_match));
        chk({tag, ".variety1"}, 32'(gif.variety1), 32'(m_v1));
        chk({tag, ".attempts"}, 32'(gif.attempts), 32'(m_att));
    endtask

    task automatic model_reset();
        m_ph = 0; m_var = 0; m_match = 0; m_v1 = 0; m_att = 0;
    endtask

    task automatic model_next();
        case (m_ph)
            0: m_var = (m_var + 1) % 4;
            1: begin
                m_match = (m_match + 1) % 4;
                if (m_match == m_var) m_match = (m_match + 1) % 4;
            end
            3: m_v1 = 3 - m_v1;
            default: ;
        endcase
    endtask

    // select, including the outcome of any reveal it starts
    task automatic model_sel();
        case (m_ph)
            0: begin m_match = (m_var == 0) ? 1 : 0; m_ph = 1; end
            1: begin
                if (m_match == 3 - m_var) begin
                    m_v1 = (m_var == 0 || m_var == 3) ? 1 : 2;
                    m_ph = 3;
                end else begin
                    if (m_att < 15) m_att++;
                    m_var = 0; m_match = 0; m_ph = 0;
                end
            end
            3: m_ph = 4;
            4: m_ph = 6;
            default: ;
        endcase
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk25MHz);
        rst = 1'b1; gif.btn_next = 1'b0; gif.btn_select = 1'b0;
        repeat (3) @(negedge clk25MHz);
        rst = 1'b0;
        model_reset();
        @(negedge clk25MHz);
        check_all(tag);
    endtask

    // Hold the button(s) long enough to be accepted, release, then check.
    // A select that starts a reveal also measures how long the reveal lasts.
    task automatic press(input bit n, input bit s, input string tag);
        bit show;
        int code, cnt;
        show = s && (m_ph == 1 || m_ph == 4);
        code = (m_ph == 1) ? 2 : 5;
        @(negedge clk25MHz);
        gif.btn_next = n; gif.btn_select = s;
        if (show) begin
            cnt = 0;
            while (gif.step !== 3'(code) && cnt < 40) begin @(negedge clk25MHz); cnt++; end
            chk({tag, ".show_step"}, 32'(gif.step), 32'(code));
            cnt = 0;
            while (gif.step === 3'(code) && cnt < 40) begin @(negedge clk25MHz); cnt++; end
            chk({tag, ".show_len"}, 32'(cnt), 32'd8);
        end else begin
            repeat (10) @(negedge clk25MHz);
        end
        gif.btn_next = 1'b0; gif.btn_select = 1'b0;
        repeat (10) @(negedge clk25MHz);
        if (s) model_sel();
        else if (n) model_next();
        check_all(tag);
    endtask

    initial begin
        int r, cnt;
        gif.btn_next = 1'b0; gif.btn_select = 1'b0;
        model_reset();
        repeat (3) @(negedge clk25MHz);
        rst = 1'b0;
        @(negedge clk25MHz);
        check_all("reset");

        // cursor wraps through all four squares, select moves to PICK2
        press(1, 0, "t1.n1"); press(1, 0, "t1.n2"); press(1, 0, "t1.n3");
        press(0, 1, "t1.sel");
        chk("t1.step_abs", 32'(gif.step), 32'd1);
        chk("t1.var_abs", 32'(gif.variety), 32'd3);

        // second-pick cursor skips the first pick
        do_reset("t2.rst");
        press(1, 0, "t2.n"); press(0, 1, "t2.sel");
        press(1, 0, "t2.m1"); chk("t2.m_is2", 32'(gif.match), 32'd2);
        press(1, 0, "t2.m2"); chk("t2.m_is3", 32'(gif.match), 32'd3);
        press(1, 0, "t2.m3"); chk("t2.m_is0", 32'(gif.match), 32'd0);

        // matched pair 0/3 -> PICK3 with variety1=1, then full win path
        do_reset("t3.rst");
        press(0, 1, "t3.sel"); press(1, 0, "t3.n1"); press(1, 0, "t3.n2");
        press(0, 1, "t3.reveal");
        chk("t3.v1_abs", 32'(gif.variety1), 32'd1);
        press(1, 0, "t6.tog");  press(0, 1, "t6.sel3");
        press(1, 0, "t6.ign4"); press(0, 1, "t6.reveal4");
        press(1, 0, "t6.win_n"); press(0, 1, "t6.win_s");
        chk("t6.win_abs", 32'(gif.step), 32'd6);

        // 16 failed pairs (0 with 2): attempts saturates at 15
        do_reset("t4.rst");
        for (int i = 0; i < 16; i++) begin
            press(0, 1, "t4.sel"); press(1, 0, "t4.n"); press(0, 1, "t4.fail");
        end
        chk("t4.sat_abs", 32'(gif.attempts), 32'd15);

        // short glitch is rejected; simultaneous next+select acts as select
        do_reset("t5.rst");
        @(negedge clk25MHz); gif.btn_next = 1'b1;
        repeat (2) @(negedge clk25MHz); gif.btn_next = 1'b0;
        repeat (12) @(negedge clk25MHz);
        check_all("t5.glitch");
        press(1, 1, "t5.both");

        // reset in the middle of the final reveal
        do_reset("t6r.rst");
        press(0, 1, "t6r.s"); press(1, 0, "t6r.n1"); press(1, 0, "t6r.n2");
        press(0, 1, "t6r.rev"); press(0, 1, "t6r.s3");
        @(negedge clk25MHz); gif.btn_select = 1'b1;
        cnt = 0;
        while (gif.step !== 3'd5 && cnt < 40) begin @(negedge clk25MHz); cnt++; end
        chk("t6r.in_show4", 32'(gif.step), 32'd5);
        repeat (3) @(negedge clk25MHz);
        rst = 1'b1; gif.btn_select = 1'b0;
        model_reset();
        @(posedge clk25MHz); #1;
        check_all("t6r.abort");
        repeat (3) @(negedge clk25MHz);
        rst = 1'b0;
        repeat (12) @(negedge clk25MHz);
        check_all("t6r.after");

        // random button traffic against the model
        do_reset("rnd.rst");
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      press(1, 0, "rnd.next");
            else if (r < 9) press(0, 1, "rnd.sel");
            else            press(1, 1, "rnd.both");
            if (m_ph == 6 && $urandom_range(0, 1) == 1) do_reset("rnd.rst2");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
